// File: rtl/simon_pkg.sv
// Shared Simon game definitions used by both the control FSM and the datapath:
// default widths, LED mode codes and the common pattern/index types.
package simon_pkg;

  localparam int DEF_PAT_W  = 4;
  localparam int DEF_ADDR_W = 6;

  localparam logic [2:0] LED_MODE_INPUT    = 3'b001;
  localparam logic [2:0] LED_MODE_PLAYBACK = 3'b010;
  localparam logic [2:0] LED_MODE_REPEAT   = 3'b100;
  localparam logic [2:0] LED_MODE_DONE     = 3'b111;

  typedef logic [DEF_PAT_W-1:0]  pattern_t;
  typedef logic [DEF_ADDR_W-1:0] idx_t;

endpackage

// File: rtl/simon_pattern_mem.sv
// Pattern sequence store: 2**ADDR_W x PAT_W, synchronous write, asynchronous read.
// Contents are deliberately not reset; the game rewrites a slot before it reads it.
module simon_pattern_mem
  import simon_pkg::*;
#(
  parameter int PAT_W  = DEF_PAT_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [PAT_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [PAT_W-1:0]  rdata
);

  logic [PAT_W-1:0] mem_q [2**ADDR_W];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/simon_datapath.sv
// Simon game datapath: sequence index/length counters, pattern store and status flags.
// Optional SIMON_HIGH_SCORE_EN adds a best-round register that survives game restarts.
module simon_datapath
  import simon_pkg::*;
#(
  parameter int PAT_W  = DEF_PAT_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              level,
  input  logic [PAT_W-1:0]  pattern,
  input  logic              m1,
  input  logic              m2,
  input  logic              m3,
  input  logic              m4,
  input  logic              count_i,
  input  logic              rst_i,
  input  logic              count_ns,
  input  logic              reset,
  output logic              legal,
  output logic              right_guess,
  output logic              i_eq_ns,
  output logic [PAT_W-1:0]  pattern_leds
`ifdef SIMON_HIGH_SCORE_EN
  ,
  output logic [ADDR_W-1:0] high_score
`endif
);

  localparam logic [ADDR_W-1:0] IDX_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] IDX_MAX  = {ADDR_W{1'b1}};

  logic [ADDR_W-1:0] i_q, i_d;
  logic [ADDR_W-1:0] n_q, n_d;
  logic [ADDR_W-1:0] n_inc_s;
  logic              level_q, level_d;
  logic [PAT_W-1:0]  mem_rd_s;
  logic              legal_s;

  function automatic logic is_onehot(input logic [PAT_W-1:0] p);
    int unsigned cnt;
    cnt = 32'd0;
    for (int b = 0; b < PAT_W; b++) begin
      cnt = cnt + {31'd0, p[b]};
    end
    return (cnt == 32'd1);
  endfunction

  // Length increment holds at full depth so the last slot is simply rewritten
  assign n_inc_s = (n_q == IDX_MAX) ? IDX_MAX : (n_q + IDX_ONE);

  // Next-state for index, length and latched difficulty
  always_comb begin
    i_d     = i_q;
    n_d     = n_q;
    level_d = level_q;
    if (reset) begin
      i_d     = IDX_ZERO;
      n_d     = IDX_ZERO;
      level_d = level;
    end else begin
      if (rst_i) begin
        i_d = IDX_ZERO;
      end else if (count_i) begin
        i_d = i_q + IDX_ONE;
      end else begin
        i_d = i_q;
      end
      if (count_ns) begin
        n_d = n_inc_s;
      end else begin
        n_d = n_q;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q     <= IDX_ZERO;
      n_q     <= IDX_ZERO;
      level_q <= 1'b0;
    end else begin
      i_q     <= i_d;
      n_q     <= n_d;
      level_q <= level_d;
    end
  end

  simon_pattern_mem #(
    .PAT_W  (PAT_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (m1 & legal_s),
    .waddr (n_q),
    .wdata (pattern),
    .raddr (i_q),
    .rdata (mem_rd_s)
  );

  assign legal_s     = level_q | is_onehot(pattern);
  assign legal       = legal_s;
  assign right_guess = (pattern == mem_rd_s);
  assign i_eq_ns     = (i_q == n_q);

  // LED source select; priority only matters if control breaks one-hot modes
  always_comb begin
    pattern_leds = {PAT_W{1'b0}};
    if (m1) begin
      pattern_leds = pattern;
    end else if (m2) begin
      pattern_leds = mem_rd_s;
    end else if (m3) begin
      pattern_leds = pattern;
    end else if (m4) begin
      pattern_leds = mem_rd_s;
    end else begin
      pattern_leds = {PAT_W{1'b0}};
    end
  end

`ifdef SIMON_HIGH_SCORE_EN
  logic [ADDR_W-1:0] high_score_q, high_score_d;

  // Best round only grows; a game restart leaves it alone
  always_comb begin
    if (count_ns && (n_inc_s > high_score_q)) begin
      high_score_d = n_inc_s;
    end else begin
      high_score_d = high_score_q;
    end
  end

  // High score register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high_score_q <= IDX_ZERO;
    end else begin
      high_score_q <= high_score_d;
    end
  end

  assign high_score = high_score_q;
`endif

endmodule

// File: doc/simon_datapath.md
Name: simon_datapath

Overview:
Datapath for the Simon memory game, driven by the Simon control FSM's `m1..m4`, `count_i`, `rst_i`, `count_ns` and `reset` strobes. It returns the status flags `legal`, `right_guess` and `i_eq_ns` to that FSM. It stores the growing pattern sequence, walks it for playback, repeat-checking and the game-over replay, and drives the pattern LEDs. It sits between the user switches/LEDs and the control FSM, clocked by the same game clock.

Parameters:
- `PAT_W`, default 4: width of one pattern (switch/LED count).
- `ADDR_W`, default 6: sequence-index width; sequence depth is 2**`ADDR_W` (64).

Ports:
- `clk`  in  1  game clock (one game step per rising edge).
- `rst`  in  1  asynchronous, active-high reset.
- `level`  in  1  difficulty switch (0 = one-hot patterns only, 1 = any pattern).
- `pattern`  in  `PAT_W`  user switch pattern.
- `m1`, `m2`, `m3`, `m4`  in  1 each  mode selects: input, playback, repeat, done.
- `count_i`  in  1  increment index `i`.
- `rst_i`  in  1  clear index `i`.
- `count_ns`  in  1  increment sequence-length register `n`.
- `reset`  in  1  synchronous game restart from control.
- `legal`  out  1  current pattern is acceptable for entry.
- `right_guess`  out  1  `pattern` equals `mem[i]`.
- `i_eq_ns`  out  1  `i == n`.
- `pattern_leds`  out  `PAT_W`  LED drive.

Behaviour:
- Async reset (`rst` high): `i` = 0, `n` = 0, `level_q` = 0 immediately. Memory contents are not reset.
  - Combinational outputs follow from these values: `i_eq_ns` = 1; `pattern_leds` = 0 while all `m*` are 0.
- `level_q`: loads `level` on any edge where `reset` = 1; holds otherwise. Difficulty therefore changes only at game restart.
- `reset` (synchronous): next edge sets `n` = 0 and `i` = 0. It overrides `count_ns`, `count_i` and `rst_i`.
- Index `i`:
  - `rst_i` = 1 → 0 on next edge.
  - Else if `count_i` = 1 → `i + 1`, wrapping modulo 2**`ADDR_W`.
  - `rst_i` beats `count_i` when both are asserted.
- Length `n`:
  - `count_ns` = 1 → `n + 1` on next edge.
  - Saturates at 2**`ADDR_W` − 1; further `count_ns` is ignored.
- Memory write: on an edge where `m1` = 1 and `legal` = 1, `mem[n]` ← `pattern`. The write is synchronous; reads are asynchronous (distributed RAM).
- Combinational flags (same-cycle, zero latency):
  - `legal` = `level_q` ? 1 : (`pattern` has exactly one bit set). All-zeros is illegal at level 0.
  - `right_guess` = (`pattern` == `mem[i]`).
  - `i_eq_ns` = (`i` == `n`).
- `pattern_leds`, priority `m1` > `m2` > `m3` > `m4`:
  - `m1`: `pattern`.
  - `m2`: `mem[i]`.
  - `m3`: `pattern`.
  - `m4`: `mem[i]`.
  - None asserted: 0.
  - Control guarantees one-hot `m*`; the priority applies only on protocol violation.
- Game semantics (enforced by control; datapath only provides the above):
  - The sequence holds entries 0..`n`.
  - Playback shows `mem[0..n]`.
  - Repeat compares one guess per edge.
  - `count_ns` after a full correct repeat extends the game; the next input writes slot `n`+1.
- Reset mid-game:
  - `rst` asserted at any point returns `i`, `n` and `level_q` to 0 asynchronously.
  - Stale memory is harmless because `n` = 0 means only `mem[0]` is used, and it is rewritten before being read.
- Saturation at full depth: at `n` = 63 with `count_ns`, `n` stays 63. The next input overwrites `mem[63]`.

Optional Feature:
- Macro `SIMON_HIGH_SCORE_EN`.
- When defined:
  - Adds output `high_score` [`ADDR_W`-1:0], a register cleared only by `rst`.
  - On each edge where `count_ns` = 1 and (`n` + 1) > `high_score`, it loads `n` + 1 (saturating, same as `n`).
  - Survives `reset`, so it holds the best round across games.
- When undefined: the port and register are absent; behaviour is otherwise identical.

Decomposition:
- Shared package `simon_pkg`:
  - `PAT_W` and `ADDR_W` defaults.
  - LED mode constants (input 3'b001, playback 3'b010, repeat 3'b100, done 3'b111).
  - `pattern_t` and `idx_t` typedefs.
  - Used by both control and datapath.
- One natural sub-module: `simon_pattern_mem`, 2**`ADDR_W` x `PAT_W` with synchronous write and asynchronous read. Everything else stays in `simon_datapath`.

Test Plan:
1. Reset/flags: pulse `rst` → `i` = 0, `n` = 0, `i_eq_ns` = 1. With `level` = 0: `pattern` = 4'b0100 gives `legal` = 1; 4'b0110 gives 0; 4'b0000 gives 0.
2. Level latch: `level` = 1 with `reset` high for one edge, then `level` = 0 → `pattern` = 4'b0110 gives `legal` = 1 until the next `reset`.
3. Write/playback: `m1`, `pattern` = 4'b0010, `legal` edge → `mem[0]` = 4'b0010. Then `m2` → `pattern_leds` = 4'b0010 and `i_eq_ns` = 1 at `i` = 0.
4. Repeat: `m3`, `pattern` = 4'b0010 → `right_guess` = 1; `count_ns` edge → `n` = 1, `i_eq_ns` = 0. `pattern` = 4'b1000 → `right_guess` = 0.
5. Index control: assert `count_i` and `rst_i` together at `i` = 3 → `i` = 0. `count_i` alone at `i` = 63 → `i` = 0.
6. Saturation/high score: 64 `count_ns` pulses → `n` stays 63. With `SIMON_HIGH_SCORE_EN`, `high_score` = 63 and remains 63 after a `reset` pulse; it is cleared to 0 only by `rst`.
